// File: rtl/bbus_arbiter.sv
// bbus_arbiter: shares the 16-bit local register bus among NREQ masters, one transaction per grant.
// Define BBUS_ARB_FIXPRI_EN to let requester 0 pre-empt the round-robin group at every arbitration.
module bbus_arbiter #(
   parameter int NREQ   = 2,
   parameter int RD_LAT = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NREQ-1:0]     req_valid,
   input  logic [NREQ-1:0]     req_wr,
   input  logic [16*NREQ-1:0]  req_addr,
   input  logic [16*NREQ-1:0]  req_wdata,
   output logic [NREQ-1:0]     req_ack,
   output logic [15:0]         rdata,
   output logic [15:0]         baddr,
   output logic [15:0]         bwrdata,
   output logic                bwr,
   output logic                bstrobe,
   input  logic [15:0]         brddata,
   output logic                busy
);
   localparam int PW = $clog2(NREQ);

   typedef enum logic [1:0] {IDLE, STROBE, WAIT, ACK} state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   last_q, last_d;
   logic [PW-1:0]   win_q, win_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [15:0]     baddr_q, baddr_d;
   logic [15:0]     bwrdata_q, bwrdata_d;
   logic            bwr_q, bwr_d;
   logic            bstrobe_q, bstrobe_d;
   logic [15:0]     rdata_q, rdata_d;
   logic [NREQ-1:0] req_ack_q, req_ack_d;
   logic            busy_q, busy_d;

   logic [NREQ-1:0] rr_req;
   logic [PW-1:0]   pick;
   logic            any_req;
   logic            upd_ptr;
   int              idx;

   // Searching from the far end lets the nearest requester after last_q overwrite pick last.
   always_comb begin
      rr_req  = req_valid;
      any_req = |req_valid;
      upd_ptr = 1'b1;
      pick    = last_q;
      idx     = 0;
`ifdef BBUS_ARB_FIXPRI_EN
      rr_req[0] = 1'b0;
`endif
      for (int i = NREQ; i >= 1; i--) begin
         idx = (int'(last_q) + i) % NREQ;
         if (rr_req[PW'(idx)]) pick = PW'(idx);
      end
`ifdef BBUS_ARB_FIXPRI_EN
      if (req_valid[0]) begin
         pick    = '0;
         upd_ptr = 1'b0;
      end
`endif
   end

   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      win_d     = win_q;
      cnt_d     = cnt_q;
      baddr_d   = baddr_q;
      bwrdata_d = bwrdata_q;
      bwr_d     = bwr_q;
      rdata_d   = rdata_q;
      bstrobe_d = 1'b0;
      req_ack_d = '0;
      case (state_q)
         IDLE: begin
            if (any_req) begin
               win_d     = pick;
               baddr_d   = req_addr[{pick, 4'b0000} +: 16];
               bwrdata_d = req_wdata[{pick, 4'b0000} +: 16];
               bwr_d     = req_wr[pick];
               bstrobe_d = 1'b1;
               state_d   = STROBE;
               if (upd_ptr) last_d = pick;
            end
         end
         STROBE: begin
            if (bwr_q) begin
               req_ack_d[win_q] = 1'b1;
               state_d          = ACK;
            end else if (RD_LAT == 0) begin
               rdata_d          = brddata;
               req_ack_d[win_q] = 1'b1;
               state_d          = ACK;
            end else begin
               cnt_d   = 4'(RD_LAT - 1);
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) begin
               rdata_d          = brddata;
               req_ack_d[win_q] = 1'b1;
               state_d          = ACK;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         last_q    <= PW'(NREQ - 1);
         win_q     <= '0;
         cnt_q     <= '0;
         baddr_q   <= '0;
         bwrdata_q <= '0;
         bwr_q     <= 1'b0;
         bstrobe_q <= 1'b0;
         rdata_q   <= '0;
         req_ack_q <= '0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         win_q     <= win_d;
         cnt_q     <= cnt_d;
         baddr_q   <= baddr_d;
         bwrdata_q <= bwrdata_d;
         bwr_q     <= bwr_d;
         bstrobe_q <= bstrobe_d;
         rdata_q   <= rdata_d;
         req_ack_q <= req_ack_d;
         busy_q    <= busy_d;
      end
   end

   assign req_ack = req_ack_q;
   assign rdata   = rdata_q;
   assign baddr   = baddr_q;
   assign bwrdata = bwrdata_q;
   assign bwr     = bwr_q;
   assign bstrobe = bstrobe_q;
   assign busy    = busy_q;

endmodule

// File: tb/tb_bbus_arbiter.sv
// Bench for bbus_arbiter: two instances (RD_LAT 0 and 3, three requesters each) against a
// transaction-level model that predicts grant, strobe, ack and read-data cycles arithmetically.
module tb_bbus_arbiter;
   localparam int N  = 3;
   localparam int ND = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            reset;
   logic [N-1:0]    req_valid_s [ND];
   logic [N-1:0]    req_wr_s    [ND];
   logic [16*N-1:0] req_addr_s  [ND];
   logic [16*N-1:0] req_wdata_s [ND];
   logic [15:0]     brddata_s   [ND];
   logic [N-1:0]    req_ack_o   [ND];
   logic [15:0]     rdata_o     [ND];
   logic [15:0]     baddr_o     [ND];
   logic [15:0]     bwrdata_o   [ND];
   logic            bwr_o       [ND];
   logic            bstrobe_o   [ND];
   logic            busy_o      [ND];

   bbus_arbiter #(.NREQ(N), .RD_LAT(0)) dut0 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid_s[0]), .req_wr(req_wr_s[0]),
      .req_addr(req_addr_s[0]), .req_wdata(req_wdata_s[0]),
      .req_ack(req_ack_o[0]), .rdata(rdata_o[0]),
      .baddr(baddr_o[0]), .bwrdata(bwrdata_o[0]), .bwr(bwr_o[0]),
      .bstrobe(bstrobe_o[0]), .brddata(brddata_s[0]), .busy(busy_o[0]));

   bbus_arbiter #(.NREQ(N), .RD_LAT(3)) dut1 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid_s[1]), .req_wr(req_wr_s[1]),
      .req_addr(req_addr_s[1]), .req_wdata(req_wdata_s[1]),
      .req_ack(req_ack_o[1]), .rdata(rdata_o[1]),
      .baddr(baddr_o[1]), .bwrdata(bwrdata_o[1]), .bwr(bwr_o[1]),
      .bstrobe(bstrobe_o[1]), .brddata(brddata_s[1]), .busy(busy_o[1]));

   // Model state: one outstanding transaction per instance, described by its cycle numbers.
   bit          m_busy   [ND];
   int          m_win    [ND];
   bit          m_wr     [ND];
   int          m_strobe [ND];
   int          m_ack    [ND];
   int          m_last   [ND];
   logic [15:0] m_baddr  [ND];
   logic [15:0] m_bwrdata[ND];
   logic [15:0] m_rdata  [ND];
   logic [N-1:0] ack_seen[ND];

   // Requester state and the bus read data driven in each cycle.
   bit          rv  [ND][N];
   bit          rw  [ND][N];
   logic [15:0] ra  [ND][N];
   logic [15:0] rwd [ND][N];
   logic [15:0] bd  [ND][4096];

   int cyc;
   int mode;   // 0: quiet, 1: random traffic, 2: everyone writes continuously
   int n_assert = 0;
   int n_fail   = 0;

   function automatic int lat(input int d);
      return (d == 0) ? 0 : 3;
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int pick_winner(input int d);
`ifdef BBUS_ARB_FIXPRI_EN
      if (rv[d][0]) return 0;
`endif
      for (int k = 1; k <= N; k++) begin
         int c;
         c = (m_last[d] + k) % N;
`ifdef BBUS_ARB_FIXPRI_EN
         if (c == 0) continue;
`endif
         if (rv[d][c]) return c;
      end
      return -1;
   endfunction

   task automatic model_reset(input int d);
      m_busy[d]    = 1'b0;
      m_win[d]     = 0;
      m_wr[d]      = 1'b0;
      m_strobe[d]  = -10;
      m_ack[d]     = -10;
      m_last[d]    = N - 1;
      m_baddr[d]   = '0;
      m_bwrdata[d] = '0;
      m_rdata[d]   = '0;
   endtask

   // Applies the clock edge that ends cycle 'cyc', using the inputs held during that cycle.
   task automatic model_edge(input int d);
      int w;
      ack_seen[d] = '0;
      if (m_busy[d] && !m_wr[d] && (cyc + 1 == m_ack[d]))
         m_rdata[d] = bd[d][m_strobe[d] + lat(d)];
      if (m_busy[d]) begin
         if (cyc == m_ack[d]) begin
            ack_seen[d][m_win[d]] = 1'b1;
            m_busy[d] = 1'b0;
         end
      end else begin
         w = pick_winner(d);
         if (w >= 0) begin
            m_busy[d]    = 1'b1;
            m_win[d]     = w;
            m_wr[d]      = rw[d][w];
            m_baddr[d]   = ra[d][w];
            m_bwrdata[d] = rwd[d][w];
            m_strobe[d]  = cyc + 1;
            m_ack[d]     = cyc + 2 + (rw[d][w] ? 0 : lat(d));
`ifdef BBUS_ARB_FIXPRI_EN
            if (w != 0) m_last[d] = w;
`else
            m_last[d] = w;
`endif
         end
      end
      if (reset) model_reset(d);
   endtask

   task automatic new_txn(input int d, input int i);
      rv[d][i]  = 1'b1;
      rw[d][i]  = (mode == 2) ? 1'b1 : 1'($urandom_range(0, 1));
      ra[d][i]  = 16'($urandom);
      rwd[d][i] = 16'($urandom);
   endtask

   task automatic pack();
      for (int d = 0; d < ND; d++) begin
         for (int i = 0; i < N; i++) begin
            req_valid_s[d][i]         = rv[d][i];
            req_wr_s[d][i]            = rw[d][i];
            req_addr_s[d][16*i +: 16] = ra[d][i];
            req_wdata_s[d][16*i +: 16] = rwd[d][i];
         end
      end
   endtask

   task automatic drive_cycle();
      for (int d = 0; d < ND; d++) begin
         for (int i = 0; i < N; i++) begin
            if (ack_seen[d][i]) begin
               if (mode == 2 || (mode == 1 && $urandom_range(0, 99) < 60)) new_txn(d, i);
               else rv[d][i] = 1'b0;
            end else if (!rv[d][i]) begin
               if (mode == 2 || (mode == 1 && $urandom_range(0, 99) < 30)) new_txn(d, i);
            end
         end
         brddata_s[d] = 16'($urandom);
         bd[d][cyc]   = brddata_s[d];
      end
      pack();
   endtask

   task automatic check_all();
      logic [N-1:0] ea;
      for (int d = 0; d < ND; d++) begin
         ea = '0;
         if (m_busy[d] && cyc == m_ack[d]) ea[m_win[d]] = 1'b1;
         chk($sformatf("d%0d c%0d req_ack", d, cyc), 16'(req_ack_o[d]), 16'(ea));
         chk($sformatf("d%0d c%0d bstrobe", d, cyc), 16'(bstrobe_o[d]),
             16'(m_busy[d] && cyc == m_strobe[d]));
         chk($sformatf("d%0d c%0d busy", d, cyc), 16'(busy_o[d]), 16'(m_busy[d]));
         chk($sformatf("d%0d c%0d baddr", d, cyc), baddr_o[d], m_baddr[d]);
         chk($sformatf("d%0d c%0d bwrdata", d, cyc), bwrdata_o[d], m_bwrdata[d]);
         chk($sformatf("d%0d c%0d bwr", d, cyc), 16'(bwr_o[d]), 16'(m_wr[d]));
         chk($sformatf("d%0d c%0d rdata", d, cyc), rdata_o[d], m_rdata[d]);
      end
   endtask

   task automatic tick(input logic rst_next);
      @(posedge clk);
      for (int d = 0; d < ND; d++) model_edge(d);
      #1;
      cyc++;
      reset = rst_next;
      drive_cycle();
      @(negedge clk);
      check_all();
   endtask

   initial begin
      int c0;
      bit found;
      reset = 1'b1;
      cyc   = 0;
      mode  = 0;
      for (int d = 0; d < ND; d++) begin
         model_reset(d);
         ack_seen[d] = '0;
         for (int i = 0; i < N; i++) begin
            rv[d][i] = 1'b0; rw[d][i] = 1'b0; ra[d][i] = '0; rwd[d][i] = '0;
         end
         brddata_s[d] = '0;
         bd[d][0]     = '0;
      end
      pack();

      // Reset state is checked by the model in the first post-reset cycle.
      tick(1'b0);
      tick(1'b0);

      // Single write on the RD_LAT=0 instance.
      rv[0][0] = 1'b1; rw[0][0] = 1'b1; ra[0][0] = 16'h0012; rwd[0][0] = 16'hBEEF;
      pack();
      tick(1'b0);
      chk("wr strobe", 16'(bstrobe_o[0]), 16'h1);
      chk("wr bwr", 16'(bwr_o[0]), 16'h1);
      chk("wr baddr", baddr_o[0], 16'h0012);
      chk("wr bwrdata", bwrdata_o[0], 16'hBEEF);
      tick(1'b0);
      chk("wr ack", 16'(req_ack_o[0]), 16'h0001);
      tick(1'b0);

      // Read by requester 1 on the RD_LAT=3 instance: ack five cycles after the request edge.
      rv[1][1] = 1'b1; rw[1][1] = 1'b0; ra[1][1] = 16'h0004;
      pack();
      c0 = cyc;
      repeat (4) tick(1'b0);
      chk("rd3 no early ack", 16'(req_ack_o[1]), 16'h0000);
      tick(1'b0);
      chk("rd3 ack", 16'(req_ack_o[1]), 16'h0002);
      chk("rd3 rdata", rdata_o[1], bd[1][c0 + 1 + 3]);
      tick(1'b0);

      // Zero-latency read: data sampled during the strobe cycle, ack two cycles after request.
      rv[0][2] = 1'b1; rw[0][2] = 1'b0; ra[0][2] = 16'h0100;
      pack();
      c0 = cyc;
      tick(1'b0);
      tick(1'b0);
      chk("rd0 ack", 16'(req_ack_o[0]), 16'h0004);
      chk("rd0 rdata", rdata_o[0], bd[0][c0 + 1]);
      tick(1'b0);

      mode = 1;
      repeat (600) tick(1'b0);

      mode = 2;
      repeat (60) tick(1'b0);

      // Reset while the RD_LAT=3 instance waits for read data.
      mode  = 1;
      found = 1'b0;
      for (int t = 0; t < 300 && !found; t++) begin
         tick(1'b0);
         if (m_busy[1] && !m_wr[1] && cyc > m_strobe[1] && cyc < m_ack[1]) found = 1'b1;
      end
      if (!found) begin
         n_assert++;
         n_fail++;
         $error("FAIL wait-state search timed out observed=none expected=read in WAIT");
      end else begin
         reset = 1'b1;
         mode  = 2;
         for (int i = 0; i < N; i++) if (!rv[1][i]) new_txn(1, i);
         pack();
         tick(1'b0);
         chk("rst bstrobe", 16'(bstrobe_o[1]), 16'h0);
         chk("rst busy", 16'(busy_o[1]), 16'h0);
         chk("rst ack", 16'(req_ack_o[1]), 16'h0);
         found = 1'b0;
         for (int t = 0; t < 20 && !found; t++) begin
            tick(1'b0);
            if (req_ack_o[1] != '0) found = 1'b1;
         end
         if (!found) begin
            n_assert++;
            n_fail++;
            $error("FAIL post-reset ack timed out observed=none expected=001");
         end else begin
            chk("post-reset first grant", 16'(req_ack_o[1]), 16'h0001);
         end
      end

      mode = 1;
      repeat (300) tick(1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
